// File: rtl/ram_port_arbiter_if.sv
// Bundle of the fetch port, data port and byte-wide RAM signals around ram_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic              d_size;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic [7:0]        ram_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, ram_addr, ram_wdata, ram_we, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, ram_addr, ram_wdata, ram_we, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a byte-wide RAM; word accesses are four
// big-endian byte beats, byte accesses one beat, each followed by a one-cycle ack.
module ram_port_arbiter #(
  parameter int ADDR_W = 8
) (
  input logic               clk,
  input logic               reset,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BEAT, ACK} state_t;

  state_t            state, state_nx;
  logic              owner_d;   // 1 = data port owns the transfer
  logic              last_d;    // 1 = data port was granted last
  logic              size_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       if_rdata_q;
  logic [31:0]       d_rdata_q;
  logic [1:0]        beat;

  logic              grant_any;
  logic              grant_d;
  logic              last_beat;
  logic [7:0]        lane_byte;
  logic [31:0]       rd_new;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W], bus.d_addr[31:ADDR_W]};

  always_comb begin
    grant_any = bus.if_req | bus.d_req;
    // On a tie the data port wins only if fetch was granted last
    grant_d   = bus.d_req & (~bus.if_req | ~last_d);
    last_beat = ~size_q | (beat == 2'd3);

    state_nx = state;
    case (state)
      IDLE:    if (grant_any) state_nx = BEAT;
      BEAT:    if (last_beat) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    case (beat)
      2'd0:    lane_byte = wdata_q[31:24];
      2'd1:    lane_byte = wdata_q[23:16];
      2'd2:    lane_byte = wdata_q[15:8];
      default: lane_byte = wdata_q[7:0];
    endcase

    rd_new = owner_d ? d_rdata_q : if_rdata_q;
    if (size_q) begin
      case (beat)
        2'd0:    rd_new[31:24] = bus.ram_rdata;
        2'd1:    rd_new[23:16] = bus.ram_rdata;
        2'd2:    rd_new[15:8]  = bus.ram_rdata;
        default: rd_new[7:0]   = bus.ram_rdata;
      endcase
    end else begin
      rd_new = {24'h0, bus.ram_rdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      last_d     <= 1'b0;
      size_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      beat       <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner_d <= grant_d;
            last_d  <= grant_d;
            addr_q  <= grant_d ? bus.d_addr[ADDR_W-1:0] : bus.if_addr[ADDR_W-1:0];
            size_q  <= grant_d ? bus.d_size : 1'b1;
            we_q    <= grant_d & bus.d_we;
            wdata_q <= bus.d_wdata;
            beat    <= '0;
          end
        end
        BEAT: begin
          beat <= beat + 2'd1;
          if (!we_q) begin
            if (owner_d) d_rdata_q  <= rd_new;
            else         if_rdata_q <= rd_new;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM-side outputs are decoded from state so reset drops them without a clock
  assign bus.ram_addr  = (state == BEAT) ? addr_q + ADDR_W'(beat) : '0;
  assign bus.ram_we    = (state == BEAT) && we_q;
  assign bus.ram_wdata = ((state == BEAT) && we_q) ? (size_q ? lane_byte : wdata_q[7:0]) : '0;
  assign bus.if_ack    = (state == ACK) && !owner_d;
  assign bus.d_ack     = (state == ACK) && owner_d;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 256-byte RAM model.
module tb_ram_port_arbiter;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [7:0]  mem [0:255];
  logic [15:0] wlog [$];

  ram_port_arbiter_if #(.ADDR_W(8)) b ();

  ram_port_arbiter #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign b.ram_rdata = mem[b.ram_addr];

  // RAM write port and write-beat log, sampled mid-cycle
  always @(negedge clk) begin
    if (b.ram_we) begin
      mem[b.ram_addr] = b.ram_wdata;
      wlog.push_back({b.ram_addr, b.ram_wdata});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered 1 time unit after an edge with the arbiter idle; returns edges from grant to ack
  task automatic txn(input bit isd, input bit we, input bit sz, input logic [31:0] addr,
                     input logic [31:0] wd, output int lat);
    if (isd) begin
      b.d_req = 1'b1; b.d_we = we; b.d_size = sz; b.d_addr = addr; b.d_wdata = wd;
    end else begin
      b.if_req = 1'b1; b.if_addr = addr;
    end
    @(posedge clk); #1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (isd ? b.d_ack : b.if_ack) begin
        lat = i;
        break;
      end
    end
    check("other_ack_low", {31'b0, isd ? b.if_ack : b.d_ack}, 32'h0);
    @(posedge clk); #1;
    check("ack_one_cycle", {31'b0, isd ? b.d_ack : b.if_ack}, 32'h0);
    check("idle_after_ack", {31'b0, b.busy}, 32'h0);
    b.if_req = 1'b0;
    b.d_req  = 1'b0;
  endtask

  int lat;
  int acks;
  bit seq [$];

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hE3; mem[1] = 8'hA0; mem[2] = 8'h10; mem[3] = 8'h05;
    b.if_req = 1'b0; b.if_addr = '0;
    b.d_req = 1'b0; b.d_we = 1'b0; b.d_size = 1'b0; b.d_addr = '0; b.d_wdata = '0;
    reset = 1'b1;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_busy",     {31'b0, b.busy},   32'h0);
    check("rst_ram_we",   {31'b0, b.ram_we}, 32'h0);
    check("rst_ram_addr", {24'b0, b.ram_addr}, 32'h0);
    check("rst_ram_wdata",{24'b0, b.ram_wdata}, 32'h0);
    check("rst_if_ack",   {31'b0, b.if_ack}, 32'h0);
    check("rst_d_ack",    {31'b0, b.d_ack},  32'h0);
    check("rst_if_rdata", b.if_rdata, 32'h0);
    check("rst_d_rdata",  b.d_rdata,  32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Word fetch from 0
    txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, lat);
    check("fetch_latency", lat, 32'd4);
    check("fetch_rdata", b.if_rdata, 32'hE3A01005);

    // Word write wrapping from 0xFE
    wlog.delete();
    txn(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h11223344, lat);
    check("wr_latency", lat, 32'd4);
    check("wr_beats", wlog.size(), 32'd4);
    if (wlog.size() == 4) begin
      check("wr_beat0", {16'b0, wlog[0]}, 32'h0000FE11);
      check("wr_beat1", {16'b0, wlog[1]}, 32'h0000FF22);
      check("wr_beat2", {16'b0, wlog[2]}, 32'h00000033);
      check("wr_beat3", {16'b0, wlog[3]}, 32'h00000144);
    end
    check("wr_keeps_d_rdata", b.d_rdata, 32'h0);

    // Word read back from 0xFE
    txn(1'b1, 1'b0, 1'b1, 32'h0000_00FE, 32'h0, lat);
    check("rd_latency", lat, 32'd4);
    check("rd_rdata", b.d_rdata, 32'h11223344);
    check("rd_keeps_if_rdata", b.if_rdata, 32'hE3A01005);

    // Byte read at 0x02
    txn(1'b1, 1'b0, 1'b0, 32'h0000_0002, 32'h0, lat);
    check("brd_latency", lat, 32'd1);
    check("brd_rdata", b.d_rdata, 32'h00000010);

    // Byte write at 0x05 uses only wdata[7:0]
    wlog.delete();
    txn(1'b1, 1'b1, 1'b0, 32'h0000_0005, 32'hCDEF12AB, lat);
    check("bwr_latency", lat, 32'd1);
    check("bwr_beats", wlog.size(), 32'd1);
    if (wlog.size() == 1) check("bwr_beat0", {16'b0, wlog[0]}, 32'h000005AB);
    check("bwr_keeps_d_rdata", b.d_rdata, 32'h00000010);

    // Reset during beat 2 of a word write to 0x10
    wlog.delete();
    b.d_req = 1'b1; b.d_we = 1'b1; b.d_size = 1'b1; b.d_addr = 32'h10; b.d_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_pre_we",   {31'b0, b.ram_we}, 32'h1);
    check("abort_pre_addr", {24'b0, b.ram_addr}, 32'h12);
    check("abort_pre_wdata",{24'b0, b.ram_wdata}, 32'hBE);
    #1 reset = 1'b1;
    #1;
    check("abort_we_async",  {31'b0, b.ram_we}, 32'h0);
    check("abort_busy",      {31'b0, b.busy},   32'h0);
    check("abort_addr",      {24'b0, b.ram_addr}, 32'h0);
    b.d_req = 1'b0;
    @(posedge clk); #1;
    check("abort_no_ack", {31'b0, b.d_ack}, 32'h0);
    check("abort_d_rdata_clr", b.d_rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", {31'b0, b.busy}, 32'h0);
    check("abort_beats", wlog.size(), 32'd2);
    check("abort_mem10", {24'b0, mem[8'h10]}, 32'hDE);
    check("abort_mem11", {24'b0, mem[8'h11]}, 32'hAD);
    check("abort_mem12", {24'b0, mem[8'h12]}, 32'h00);

    // Back-to-back ties: data, fetch, data
    b.if_req = 1'b1; b.if_addr = 32'h0;
    b.d_req = 1'b1; b.d_we = 1'b0; b.d_size = 1'b1; b.d_addr = 32'hFE;
    acks = 0;
    for (int i = 0; i < 30 && acks < 3; i++) begin
      @(posedge clk); #1;
      if (b.if_ack || b.d_ack) begin
        check("tie_single_ack", {31'b0, b.if_ack & b.d_ack}, 32'h0);
        seq.push_back(b.d_ack);
        acks++;
        if (b.d_ack) check("tie_d_rdata", b.d_rdata, 32'h11223344);
        else         check("tie_if_rdata", b.if_rdata, 32'h33441005);
      end
    end
    check("tie_ack_count", acks, 32'd3);
    if (seq.size() == 3) begin
      check("tie_grant0_data",  {31'b0, seq[0]}, 32'h1);
      check("tie_grant1_fetch", {31'b0, seq[1]}, 32'h0);
      check("tie_grant2_data",  {31'b0, seq[2]}, 32'h1);
    end
    @(posedge clk); #1;
    b.if_req = 1'b0;
    b.d_req  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("final_idle", {31'b0, b.busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
